arm_result_monitor: RTL and testbench

Memory-bus result monitor sitting directly downstream of the multicycle ARM `top` memory interface. It snoops `MemWrite`/`Adr`/`WriteData` and keeps a small store log that the bench drains over a valid/ready port. A store to a designated mailbox address ends the run with pass/fail. A cycle watchdog ends the run with a timeout otherwise. It replaces ad-hoc cycle counting and hierarchical register peeking in benches with a synthesizable, checkable completion signal.

---
 rtl/arm_mon_pkg.sv | 18 +
 rtl/store_log_fifo.sv | 55 +++++
 rtl/arm_result_monitor.sv | 94 +++++++++
 tb/tb_arm_result_monitor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arm_mon_pkg.sv
// Shared types and defaults for the ARM memory-bus result monitor.
package arm_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } log_entry_t;

  localparam logic [31:0] DONE_ADDR_DEFAULT  = 32'h0000_00FC;
  localparam logic [31:0] PASS_VALUE_DEFAULT = 32'h0000_0001;

endpackage

// File: rtl/store_log_fifo.sv
// Synchronous FIFO of log entries; head visible one cycle after push into empty.
// Push on a full FIFO is accepted only when a pop happens on the same edge.
module store_log_fifo
  import arm_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  log_entry_t push_dat,
  input  logic       pop,
  output log_entry_t pop_dat,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  log_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            wr_en;
  logic            rd_en;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Head reads as zero when empty so stale storage never leaks out after reset.
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/arm_result_monitor.sv
// Snoops ARM stores, logs them, and ends the run on a mailbox store or watchdog.
// Status outputs are registered; log drains over valid/ready, overflow is sticky.
module arm_result_monitor
  import arm_mon_pkg::*;
#(
  parameter logic [31:0] DONE_ADDR      = DONE_ADDR_DEFAULT,
  parameter logic [31:0] PASS_VALUE     = PASS_VALUE_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 400,
  parameter int          LOG_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_adr,
  output logic [31:0] log_data,
  output logic        log_overflow,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] result,
  output logic [31:0] cycle_count,
  output logic [15:0] store_count
);

  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  mon_state_t state, state_nxt;
  log_entry_t head_dat;
  logic       in_run;
  logic       mailbox_hit;
  logic       log_push;
  logic       log_pop;
  logic       log_full;
  logic       log_empty;

  assign in_run      = (state == ST_RUN);
  assign mailbox_hit = in_run && MemWrite && (Adr == DONE_ADDR);
  assign log_push    = in_run && MemWrite && !mailbox_hit;
  assign log_pop     = log_valid && log_ready;

  store_log_fifo #(.DEPTH(LOG_DEPTH)) u_log (
    .clk      (clk),
    .rst_n    (reset),
    .push     (log_push),
    .push_dat ('{adr: Adr, data: WriteData}),
    .pop      (log_pop),
    .pop_dat  (head_dat),
    .full     (log_full),
    .empty    (log_empty)
  );

  assign log_valid = !log_empty;
  assign log_adr   = head_dat.adr;
  assign log_data  = head_dat.data;
  assign done      = (state == ST_DONE);
  assign timeout   = (state == ST_TIMEOUT);

  always_comb begin
    state_nxt = state;
    case (state)
      // Mailbox beats the watchdog when both land on the same edge.
      ST_RUN: begin
        if (mailbox_hit)                 state_nxt = ST_DONE;
        else if (cycle_count == WD_LAST) state_nxt = ST_TIMEOUT;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      pass         <= 1'b0;
      result       <= '0;
      cycle_count  <= '0;
      store_count  <= '0;
      log_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_run && cycle_count != '1) cycle_count <= cycle_count + 32'd1;
      if (in_run && MemWrite && store_count != '1) store_count <= store_count + 16'd1;
      if (mailbox_hit) begin
        result <= WriteData;
        pass   <= (WriteData == PASS_VALUE);
      end
      if (log_push && log_full && !log_pop) log_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arm_result_monitor.sv
// Directed bench: expected log entries go into a scoreboard queue drained by a monitor.
module tb_arm_result_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_adr;
  logic [31:0] log_data;
  logic        log_overflow;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] result;
  logic [31:0] cycle_count;
  logic [15:0] store_count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  arm_result_monitor #(
    .DONE_ADDR      (32'h0000_00FC),
    .PASS_VALUE     (32'h0000_0001),
    .TIMEOUT_CYCLES (10),
    .LOG_DEPTH      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .Adr          (Adr),
    .WriteData    (WriteData),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_adr      (log_adr),
    .log_data     (log_data),
    .log_overflow (log_overflow),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .result       (result),
    .cycle_count  (cycle_count),
    .store_count  (store_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle; the pop happens on the following rising edge.
  always @(negedge clk) begin
    if (reset === 1'b1 && log_valid && log_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL log_extra: got %0h/%0h expected no entry", log_adr, log_data);
      end else begin
        chk("log_entry", {log_adr, log_data}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit logged);
    MemWrite  = 1'b1;
    Adr       = a;
    WriteData = d;
    if (logged) exp_q.push_back({a, d});
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    MemWrite  = 1'b0;
    Adr       = '0;
    WriteData = '0;
    log_ready = 1'b0;
    exp_q.delete();
    step();
    reset = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_log_valid"}, 64'(log_valid), 64'd0);
    chk({tag, "_log_head"}, {log_adr, log_data}, 64'd0);
    chk({tag, "_flags"}, 64'({log_overflow, done, pass, timeout}), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_counts"}, {cycle_count, 16'd0, store_count}, 64'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_reset_vals("rst");

    // Pass run: three logged stores then a passing mailbox store
    do_reset();
    log_ready = 1'b1;
    wr(32'h10, 32'd1, 1'b1);
    wr(32'h14, 32'd2, 1'b1);
    wr(32'h18, 32'd3, 1'b1);
    wr(32'hFC, 32'd1, 1'b0);
    chk("pass_flags", 64'({done, pass, timeout}), 64'b110);
    chk("pass_result", 64'(result), 64'd1);
    chk("pass_store_count", 64'(store_count), 64'd4);
    repeat (3) step();
    chk("pass_cycle_frozen", 64'(cycle_count), 64'd4);
    chk("pass_log_drained", 64'(log_valid), 64'd0);
    chk("pass_q_empty", 64'(exp_q.size()), 64'd0);

    // Fail run: later stores ignored
    do_reset();
    log_ready = 1'b1;
    wr(32'hFC, 32'h0000_DEAD, 1'b0);
    chk("fail_flags", 64'({done, pass, timeout}), 64'b100);
    chk("fail_result", 64'(result), 64'h0000_DEAD);
    wr(32'h20, 32'd5, 1'b0);
    step();
    chk("fail_store_count", 64'(store_count), 64'd1);
    chk("fail_no_log", 64'(log_valid), 64'd0);

    // Timeout after the 10th edge
    do_reset();
    repeat (9) step();
    chk("wd_before", 64'({timeout, cycle_count}), {32'd0, 1'b0, 32'd9});
    step();
    chk("wd_fire", 64'({done, timeout}), 64'b01);
    chk("wd_cycle_count", 64'(cycle_count), 64'd10);
    repeat (5) step();
    chk("wd_frozen", 64'({timeout, cycle_count}), {32'd0, 1'b1, 32'd10});

    // Mailbox and watchdog on the same edge
    do_reset();
    repeat (9) step();
    wr(32'hFC, 32'd1, 1'b0);
    chk("tie_flags", 64'({done, pass, timeout}), 64'b110);
    chk("tie_cycle_count", 64'(cycle_count), 64'd10);

    // Overflow: fifth store dropped, first four drained in order
    do_reset();
    for (int i = 0; i < 5; i++) wr(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), i < 4);
    chk("ovf_flag", 64'(log_overflow), 64'd1);
    chk("ovf_head", {log_adr, log_data}, {32'h100, 32'hA0});
    chk("ovf_store_count", 64'(store_count), 64'd5);
    log_ready = 1'b1;
    repeat (5) step();
    chk("ovf_drained", 64'(log_valid), 64'd0);
    chk("ovf_q_empty", 64'(exp_q.size()), 64'd0);

    // Full log with a simultaneous pop accepts the new store
    do_reset();
    for (int i = 0; i < 4; i++) wr(32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1);
    log_ready = 1'b1;
    wr(32'h300, 32'h55, 1'b1);
    chk("fullpop_no_ovf", 64'(log_overflow), 64'd0);
    repeat (6) step();
    chk("fullpop_q_empty", 64'(exp_q.size()), 64'd0);
    chk("fullpop_drained", 64'(log_valid), 64'd0);

    // Asynchronous reset between edges
    do_reset();
    wr(32'h40, 32'h11, 1'b1);
    wr(32'h44, 32'h22, 1'b1);
    wr(32'hFC, 32'd1, 1'b0);
    chk("arst_pre", 64'({done, log_valid}), 64'b11);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_vals("arst");
    step();
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
